bin2bcd_seq: RTL and testbench
==============================

// Module: bin2bcd_seq
// PURPOSE
//   Sequential binary-to-BCD converter using shift-and-add-3 ("double dabble"), one bit per clock.
//   Sits directly upstream of the 7-segment decoders: each 4-bit slice of bcd drives one
//   decoder input and is always a legal digit 0..9.
//   Start/busy/done handshake; the result is held stable between conversions so displays do not flicker.
// PARAMETERS
//   WIDTH   8  binary input width in bits; legal range 4..16
//   DIGITS  3  number of BCD output digits; must satisfy 10**DIGITS > 2**WIDTH-1
// PORTS
//   clk    in   1           rising-edge clock
//   rst    in   1           asynchronous reset, active-high
//   start  in   1           conversion request, sampled on clk rise while idle
//   bin    in   WIDTH       unsigned binary operand, sampled with start
//   busy   out  1           high while a conversion is in progress
//   done   out  1           one-cycle pulse: bcd has just been updated
//   bcd    out  4*DIGITS    result; digit i occupies bits [4i+3:4i], digit 0 = units
// BEHAVIOUR
//   Reset (asynchronous, active-high):
//   - Forces state=IDLE, busy=0, done=0, bcd=0, and clears the internal shift register and counter.
//   - Takes effect immediately on assertion.
//   - Mid-conversion reset aborts the conversion: no done pulse and bcd=0.
//   State machine: IDLE, SHIFT.
//   - IDLE: on an edge with start=1, latch bin into the operand shift register, clear the BCD scratch,
//     load counter=WIDTH, and go to SHIFT. busy=1 from that edge.
//   - SHIFT, each edge:
//     - every scratch digit >=5 has 3 added (4-bit, no carry out);
//     - then {scratch,operand} shifts left 1, operand MSB entering scratch bit 0;
//     - counter decrements.
//   - On the edge where counter goes 1->0:
//     - the final shifted scratch loads into bcd, done<=1, busy<=0, state<=IDLE.
//   Timing:
//   - done is registered and high for exactly the one cycle after that edge.
//   - Latency: start sampled at edge k gives bcd valid and done=1 after edge k+WIDTH (8 cycles by default).
//   - Throughput is one conversion per WIDTH+1 cycles minimum.
//   Handshake rules:
//   - start while busy=1 is ignored; bin is not resampled.
//   - start in the done cycle is accepted, because state is already IDLE; it gives back-to-back conversions.
//   - bin may change freely after the start edge.
//   Output holding:
//   - bcd holds the previous result throughout a conversion.
//   - bcd changes only on completion or reset.
//   Arithmetic:
//   - Counter width is $clog2(WIDTH+1).
//   - Scratch is 4*DIGITS bits; bits shifted out of the top of scratch are discarded.
//   - The DIGITS constraint guarantees no loss. A violating parameter set is a configuration error:
//     elaboration must fail via a generate-time check.
//   - Each output digit is always <=9 after any completed conversion.
// TESTING
//   1. rst=1 then release; no start -> busy=0, done=0, bcd=12'h000 indefinitely.
//   2. bin=8'd255, start 1 cycle -> busy=1 for 8 cycles, then done=1 for 1 cycle, bcd=12'h255.
//   3. bin=0 -> bcd=12'h000 with a done pulse. bin=99 -> 12'h099. bin=100 -> 12'h100.
//      bin=8'd128 -> 12'h128.
//   4. Convert 8'd42. Hold start=1 through the done cycle with bin=8'd7.
//      -> two done pulses 9 cycles apart; bcd 12'h042 then 12'h007.
//   5. Start with 8'd200. At cycle 3 pulse start with bin=8'd13.
//      -> second start ignored; bcd=12'h200 at done; only one done pulse.
//   6. Start with 8'd250. Assert rst asynchronously mid-cycle at cycle 4.
//      -> busy=0, bcd=0 immediately; no done pulse.
//      Restart with 8'd9 -> 12'h009.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// The result register is only written on completion or reset, so downstream
// 7-segment decoders see a steady value for the whole conversion.
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = 4 * DIGITS;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    // Reject parameter sets that cannot hold every input value.
    localparam longint MAX_BIN   = (64'd1 << WIDTH) - 64'd1;
    localparam longint DEC_RANGE = 64'(10 ** DIGITS);

    generate
        if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
            $error("bin2bcd_seq: WIDTH must lie in 4..16");
        end
        if (DEC_RANGE <= MAX_BIN) begin : g_bad_digits
            $error("bin2bcd_seq: DIGITS too small to represent 2**WIDTH-1");
        end
    endgenerate

    logic [0:0]       state_reg;
    logic [WIDTH-1:0] operand_reg;
    logic [SW-1:0]    scratch_reg;
    logic [CW-1:0]    count_reg;
    logic [SW-1:0]    bcd_reg;
    logic             done_reg;

    // Adjusted-and-shifted scratch value for one SHIFT step.
    logic [SW-1:0]     scratch_next;
    // Bit 3 of each adjusted digit, which becomes bit 0 of the digit above.
    logic [DIGITS-2:0] hi_bit;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] digit;
            assign digit = scratch_reg[4*gi +: 4];

            if (gi == DIGITS - 1) begin : g_top
                // The top digit's bit 3 is shifted out and discarded, so only
                // the low three bits of its adjusted value are needed.
                logic [2:0] adj_lo;
                assign adj_lo = (digit >= 4'd5) ? (digit[2:0] + 3'd3) : digit[2:0];
                if (gi == 0) begin : g_in_op
                    assign scratch_next[4*gi +: 4] = {adj_lo, operand_reg[WIDTH-1]};
                end else begin : g_in_hi
                    assign scratch_next[4*gi +: 4] = {adj_lo, hi_bit[gi-1]};
                end
            end else begin : g_low
                logic [3:0] adj;
                assign adj        = (digit >= 4'd5) ? (digit + 4'd3) : digit;
                assign hi_bit[gi] = adj[3];
                if (gi == 0) begin : g_in_op
                    assign scratch_next[4*gi +: 4] = {adj[2:0], operand_reg[WIDTH-1]};
                end else begin : g_in_hi
                    assign scratch_next[4*gi +: 4] = {adj[2:0], hi_bit[gi-1]};
                end
            end
        end
    endgenerate

    // Control FSM, datapath shift and result register; reset aborts any conversion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            operand_reg <= '0;
            scratch_reg <= '0;
            count_reg   <= '0;
            bcd_reg     <= '0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        operand_reg <= bin;
                        scratch_reg <= '0;
                        count_reg   <= CW'(WIDTH);
                        state_reg   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch_reg <= scratch_next;
                    operand_reg <= {operand_reg[WIDTH-2:0], 1'b0};
                    count_reg   <= count_reg - CW'(1);
                    if (count_reg == CW'(1)) begin
                        bcd_reg   <= scratch_next;
                        done_reg  <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy = (state_reg == SHIFT);
    assign done = done_reg;
    assign bcd  = bcd_reg;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed checks of the sequential binary-to-BCD converter.
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  bin;
    logic        busy;
    logic        done;
    logic [11:0] bcd;

    int vectors     = 0;
    int miscompares = 0;
    logic [11:0] last_bcd = 12'h000;

    bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full conversion with a one-cycle start pulse; checks every cycle.
    task automatic convert(input logic [7:0] value, input logic [11:0] exp_bcd, input string tag);
        @(negedge clk);
        bin   = value;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        bin   = 8'hA5;
        check({tag, " busy@start"}, 32'(busy), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (i < 8) begin
                check({tag, " busy"}, 32'(busy), 32'd1);
                check({tag, " nodone"}, 32'(done), 32'd0);
                check({tag, " hold"}, 32'(bcd), 32'(last_bcd));
            end else begin
                check({tag, " done"}, 32'(done), 32'd1);
                check({tag, " idle"}, 32'(busy), 32'd0);
                check({tag, " bcd"}, 32'(bcd), 32'(exp_bcd));
            end
        end
        @(posedge clk);
        #1;
        check({tag, " done_low"}, 32'(done), 32'd0);
        check({tag, " bcd_held"}, 32'(bcd), 32'(exp_bcd));
        last_bcd = exp_bcd;
        $display("conv bin=%0d bcd=%03h expected=%03h", value, bcd, exp_bcd);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        bin   = 8'd0;

        // 1: reset and idle
        repeat (2) @(posedge clk);
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst bcd", 32'(bcd), 32'h000);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("idle busy", 32'(busy), 32'd0);
            check("idle done", 32'(done), 32'd0);
            check("idle bcd", 32'(bcd), 32'h000);
        end
        $display("reset/idle checked");

        // 2 and 3: single conversions
        convert(8'd255, 12'h255, "c255");
        convert(8'd0,   12'h000, "c0");
        convert(8'd99,  12'h099, "c99");
        convert(8'd100, 12'h100, "c100");
        convert(8'd128, 12'h128, "c128");

        // 4: start held high through the done cycle -> back-to-back conversions
        @(negedge clk);
        bin   = 8'd42;
        start = 1'b1;
        @(posedge clk);
        #1;
        bin = 8'd7;
        for (int i = 1; i <= 17; i++) begin
            @(posedge clk);
            #1;
            if (i == 9) start = 1'b0;
            check("b2b done", 32'(done), (i == 8 || i == 17) ? 32'd1 : 32'd0);
            check("b2b busy", 32'(busy), (i == 8 || i == 17) ? 32'd0 : 32'd1);
            check("b2b bcd", 32'(bcd), (i < 8) ? 32'(last_bcd) : ((i < 17) ? 32'h042 : 32'h007));
        end
        last_bcd = 12'h007;
        $display("back-to-back 42,7 bcd=%03h", bcd);

        // 5: start pulse while busy is ignored
        @(negedge clk);
        bin   = 8'd200;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= 18; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) begin
                start = 1'b1;
                bin   = 8'd13;
            end
            if (i == 4) start = 1'b0;
            check("ign done", 32'(done), (i == 8) ? 32'd1 : 32'd0);
            check("ign busy", 32'(busy), (i < 8) ? 32'd1 : 32'd0);
            check("ign bcd", 32'(bcd), (i < 8) ? 32'(last_bcd) : 32'h200);
        end
        last_bcd = 12'h200;
        $display("start-while-busy 200 bcd=%03h", bcd);

        // 6: asynchronous reset mid-conversion
        @(negedge clk);
        bin   = 8'd250;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            check("abort busy", 32'(busy), 32'd1);
        end
        #3;
        rst = 1'b1;
        #1;
        check("async busy", 32'(busy), 32'd0);
        check("async done", 32'(done), 32'd0);
        check("async bcd", 32'(bcd), 32'h000);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("post-rst done", 32'(done), 32'd0);
            check("post-rst busy", 32'(busy), 32'd0);
            check("post-rst bcd", 32'(bcd), 32'h000);
        end
        last_bcd = 12'h000;
        $display("abort 250 by reset bcd=%03h", bcd);
        convert(8'd9, 12'h009, "c9");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
